alu_seq: RTL and testbench

Parametrised sequential ALU and the successor of the current 8-bit single-cycle ALU. It adds a valid/ready handshake on both input and output, iterative multi-cycle multiply/divide/modulo, status flags and a configurable width. It sits between an operand source and a result consumer, and processes one operation at a time.

---
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 tb/tb_alu_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready handshake, iterative shift-add multiply and restoring divide.
// Define ALU_DIV_EN to build the divider; otherwise div/mod finish in one cycle with err set.
module alu_seq #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_MOD = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]         r_sel, w_sel_nxt;
    logic [WIDTH-1:0]   r_opb, w_opb_nxt;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic               r_carry, w_carry_nxt;
    logic               r_zero, w_zero_nxt;
    logic               r_err, w_err_nxt;
    logic               w_load;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;

    assign w_add = {1'b0, in1} + {1'b0, in2};
    assign w_sub = {1'b0, in1} - {1'b0, in2};

    // r_acc holds {partial product high half, remaining multiplier bits}
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_step;

    // r_acc holds {partial remainder, dividend bits shifting into quotient}
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opb};
    assign w_div_step  = w_div_trial[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign err       = r_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sel_nxt    = r_sel;
        w_opb_nxt    = r_opb;
        w_acc_nxt    = r_acc;
        w_result_nxt = r_result;
        w_carry_nxt  = r_carry;
        w_zero_nxt   = r_zero;
        w_err_nxt    = r_err;
        w_load       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_sel_nxt   = sel;
                    w_opb_nxt   = in2;
                    w_cnt_nxt   = CNT_W'(WIDTH);
                    w_carry_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = DONE;
                    w_load      = 1'b1;
                    unique case (sel)
                        OP_ADD: begin
                            w_result_nxt = w_add[WIDTH-1:0];
                            w_carry_nxt  = w_add[WIDTH];
                        end
                        OP_SUB: begin
                            w_result_nxt = w_sub[WIDTH-1:0];
                            w_carry_nxt  = w_sub[WIDTH];
                        end
                        OP_MUL: begin
                            w_acc_nxt   = {{WIDTH{1'b0}}, in1};
                            w_state_nxt = CALC;
                            w_load      = 1'b0;
                        end
                        OP_MOD, OP_DIV: begin
`ifdef ALU_DIV_EN
                            if (in2 == '0) begin
                                w_err_nxt    = 1'b1;
                                w_result_nxt = (sel == OP_DIV) ? '1 : in1;
                            end else begin
                                w_acc_nxt   = {{WIDTH{1'b0}}, in1};
                                w_state_nxt = CALC;
                                w_load      = 1'b0;
                            end
`else
                            w_err_nxt    = 1'b1;
                            w_result_nxt = '0;
`endif
                        end
                        OP_AND:  w_result_nxt = in1 & in2;
                        OP_OR:   w_result_nxt = in1 | in2;
                        OP_XOR:  w_result_nxt = in1 ^ in2;
                        default: w_result_nxt = '0;
                    endcase
                end
            end
            CALC: begin
                w_cnt_nxt = r_cnt - 1'b1;
`ifdef ALU_DIV_EN
                w_acc_nxt = (r_sel == OP_MUL) ? w_mul_step : w_div_step;
`else
                w_acc_nxt = w_mul_step;
`endif
                // Last iteration: the result is taken from this cycle's step value
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt  = DONE;
                    w_load       = 1'b1;
                    w_result_nxt = w_mul_step[WIDTH-1:0];
                    w_carry_nxt  = |w_mul_step[2*WIDTH-1:WIDTH];
`ifdef ALU_DIV_EN
                    if (r_sel == OP_DIV) begin
                        w_result_nxt = w_div_step[WIDTH-1:0];
                        w_carry_nxt  = 1'b0;
                    end else if (r_sel == OP_MOD) begin
                        w_result_nxt = w_div_step[2*WIDTH-1:WIDTH];
                        w_carry_nxt  = 1'b0;
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_load) begin
            w_zero_nxt = (w_result_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel    <= w_sel_nxt;
            r_opb    <= w_opb_nxt;
            r_acc    <= w_acc_nxt;
            r_result <= w_result_nxt;
            r_carry  <= w_carry_nxt;
            r_zero   <= w_zero_nxt;
            r_err    <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: a driver pushes expected responses from an arithmetic reference
// model into a queue; an independent monitor pops and compares on every presented result.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   sel = 3'b000;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         err;

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic         err;
        int           lat;
        int           acceptCyc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   busy = 1'b0;
    bit   randReady = 1'b0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain integer arithmetic on the operation's definition
    function automatic exp_t model(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t m;
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint unsigned full;
        m.res = '0; m.carry = 1'b0; m.err = 1'b0; m.lat = 0; m.acceptCyc = 0;
        case (s)
            3'd0: begin full = ua + ub; m.res = W'(full); m.carry = (full >= (64'd1 << W)); end
            3'd1: begin m.res = W'(ua - ub); m.carry = (ua < ub); end
            3'd2: begin full = ua * ub; m.res = W'(full); m.carry = ((full >> W) != 0); m.lat = W; end
            3'd3, 3'd4: begin
`ifdef ALU_DIV_EN
                if (ub == 0) begin
                    m.err = 1'b1;
                    m.res = (s == 3'd4) ? W'((64'd1 << W) - 1) : a;
                end else begin
                    m.res = (s == 3'd4) ? W'(ua / ub) : W'(ua % ub);
                    m.lat = W;
                end
`else
                m.err = 1'b1;
                m.res = '0;
`endif
            end
            3'd5: m.res = a & b;
            3'd6: m.res = a | b;
            default: m.res = a ^ b;
        endcase
        m.zero = (m.res == '0);
        return m;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Called at posedge+1; waits for in_ready, issues one operation and scoreboards it
    task automatic applyStimulus(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int waitCnt = 0;
        while (!in_ready && waitCnt < 200) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        sel = s;
        in1 = a;
        in2 = b;
        @(posedge clk); #1;
        e = model(s, a, b);
        e.acceptCyc = cyc;
        q.push_back(e);
        busy = 1'b1;
        in_valid = 1'b0;
        in1 = W'($urandom);
        in2 = W'($urandom);
        sel = 3'($urandom);
    endtask

    // Monitor: samples on the falling edge, away from DUT updates
    initial begin
        exp_t cur;
        bit haveCur = 1'b0;
        bit prevValid = 1'b0;
        bit prevHs = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prevValid = 1'b0;
                prevHs = 1'b0;
                haveCur = 1'b0;
            end else begin
                if (prevHs) checkOutput("out_valid_drop", out_valid, 0);
                checkOutput("in_ready", in_ready, !busy);
                if (out_valid) begin
                    if (!prevValid) begin
                        if (q.size() == 0) begin
                            checkOutput("unexpected_out_valid", 1, 0);
                        end else begin
                            cur = q.pop_front();
                            haveCur = 1'b1;
                            checkOutput("latency", cyc - cur.acceptCyc, cur.lat);
                            checkOutput("result", result, cur.res);
                            checkOutput("carry", carry, cur.carry);
                            checkOutput("zero", zero, cur.zero);
                            checkOutput("err", err, cur.err);
                        end
                    end else if (haveCur) begin
                        checkOutput("hold_result", result, cur.res);
                        checkOutput("hold_zero", zero, cur.zero);
                    end
                end
                prevHs = out_valid && out_ready;
                if (prevHs) begin
                    busy = 1'b0;
                    haveCur = 1'b0;
                end
                prevValid = out_valid;
            end
        end
    end

    // Random consumer backpressure when enabled
    initial begin
        forever begin
            @(posedge clk); #2;
            if (randReady) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int drain;
        #12;
        checkOutput("rst_result", result, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_flags", {carry, zero, err}, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_in_ready", in_ready, 1);

        $display("[TB] directed operations");
        applyStimulus(3'd0, 8'd200, 8'd100);
        applyStimulus(3'd1, 8'd3, 8'd5);
        applyStimulus(3'd3, 8'd5, 8'd3);
        applyStimulus(3'd4, 8'd200, 8'd7);
        applyStimulus(3'd2, 8'd16, 8'd20);
        applyStimulus(3'd2, 8'd15, 8'd15);
        applyStimulus(3'd4, 8'd9, 8'd0);
        applyStimulus(3'd3, 8'd9, 8'd0);
        applyStimulus(3'd4, 8'd9, 8'd3);
        applyStimulus(3'd3, 8'd0, 8'd0);
        applyStimulus(3'd2, 8'd255, 8'd255);
        applyStimulus(3'd1, 8'd7, 8'd7);

        $display("[TB] backpressure");
        while (busy) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        applyStimulus(3'd7, 8'hAA, 8'hAA);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("bp_out_valid", out_valid, 1);
        checkOutput("bp_in_ready", in_ready, 0);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;

        $display("[TB] reset during multiply");
        applyStimulus(3'd2, 8'd16, 8'd20);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        q.delete();
        busy = 1'b0;
        #1;
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_flags", {carry, zero, err}, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abort_no_valid", out_valid, 0);
        applyStimulus(3'd0, 8'd1, 8'd1);

        $display("[TB] randomized operations");
        randReady = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            applyStimulus(3'($urandom_range(0, 7)), a, b);
        end

        drain = 0;
        while ((busy || q.size() != 0) && drain < 300) begin
            @(posedge clk); #1;
            drain++;
        end
        randReady = 1'b0;
        out_ready = 1'b1;
        if (busy || q.size() != 0) checkOutput("drain_timeout", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
